// File: rtl/ir_receiver_sm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ir_receiver_sm_pkg
//  Purpose  : Shared constants, state type and burst-classification helpers
//             for the car-control IR packet receiver.
//             Burst classes (carrier pulses per burst):
//               START_BURST          - opens a packet
//               CAR_SELECT_BURST[i]  - selects car i
//               ASSERT_BURST         - data bit 1
//               DEASSERT_BURST       - data bit 0
//  Revision : 1.0 - initial release
// ============================================================================
package ir_receiver_sm_pkg;

    localparam int CMD_LEN        = 4;
    localparam int CAR_COUNT      = 4;
    localparam int CAR_ID_W       = (CAR_COUNT > 1) ? $clog2(CAR_COUNT) : 1;
    localparam int BIT_IDX_W      = (CMD_LEN > 1) ? $clog2(CMD_LEN) : 1;
    localparam int LEN_W          = 9;

    localparam int START_BURST    = 191;
    localparam int ASSERT_BURST   = 47;
    localparam int DEASSERT_BURST = 22;
    localparam int CAR_SELECT_BURST [CAR_COUNT] = '{72, 97, 122, 147};

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        WAIT_CAR   = 2'd1,
        WAIT_BITS  = 2'd2
    } rx_state_t;

    // True when the measured length lies inside target +/- tol.
    function automatic logic burst_match(input logic [LEN_W-1:0] len,
                                         input int target,
                                         input int tol);
        int l;
        l = 32'(len);
        return (l >= target - tol) && (l <= target + tol);
    endfunction

    // Enumerates every burst class: cars first, then start, assert, deassert.
    function automatic int class_len(input int idx);
        if (idx < CAR_COUNT)
            return CAR_SELECT_BURST[CAR_ID_W'(idx)];
        else if (idx == CAR_COUNT)
            return START_BURST;
        else if (idx == CAR_COUNT + 1)
            return ASSERT_BURST;
        else
            return DEASSERT_BURST;
    endfunction

    // Two windows of half-width tol are disjoint when centres differ by > 2*tol.
    function automatic bit classes_disjoint(input int tol);
        bit ok;
        int d;
        ok = 1'b1;
        for (int a = 0; a < CAR_COUNT + 3; a++) begin
            for (int b = a + 1; b < CAR_COUNT + 3; b++) begin
                d = class_len(a) - class_len(b);
                if (d < 0)
                    d = -d;
                if (d <= 2 * tol)
                    ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_receiver_sm_burst_meter.sv
`default_nettype none
// ============================================================================
//  Module   : ir_receiver_sm_burst_meter
//  Purpose  : Synchronises the raw IR input, detects carrier rising edges and
//             measures burst length in carrier pulses. A burst ends once no
//             edge has been seen for EDGE_TIMEOUT clocks.
//  Ports    : clk           in   system clock
//             rst_n         in   asynchronous active-low reset
//             i_ir_in       in   raw modulated IR input (asynchronous)
//             o_burst_done  out  1-cycle strobe: burst finished
//             o_burst_len   out  pulse count of the finished burst
//             o_busy        out  a burst is currently being counted
//  Revision : 1.0 - initial release
// ============================================================================
module ir_receiver_sm_burst_meter
    import ir_receiver_sm_pkg::*;
#(
    parameter int EDGE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ir_in,
    output logic             o_burst_done,
    output logic [LEN_W-1:0] o_burst_len,
    output logic             o_busy
);

    localparam int c_idle_w = $clog2(EDGE_TIMEOUT + 1);
    localparam logic [c_idle_w-1:0] c_timeout = c_idle_w'(EDGE_TIMEOUT);

    logic [1:0]          r_sync;
    logic                r_prev;
    logic                r_edge;
    logic [LEN_W-1:0]    r_pulse_cnt;
    logic [c_idle_w-1:0] r_idle_cnt;
    logic                w_done;

    // Idle counter parks at the timeout value, so the strobe fires once per
    // burst: the pulse count is cleared in the same cycle.
    assign w_done       = (r_idle_cnt == c_timeout) && (r_pulse_cnt != '0);
    assign o_burst_done = w_done;
    assign o_burst_len  = r_pulse_cnt;
    assign o_busy       = (r_pulse_cnt != '0);

    // Registered edge pulse puts the counted edge three clocks after the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_prev      <= 1'b0;
            r_edge      <= 1'b0;
            r_pulse_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_ir_in};
            r_prev <= r_sync[1];
            r_edge <= r_sync[1] & ~r_prev;

            if (r_edge)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != c_timeout)
                r_idle_cnt <= r_idle_cnt + c_idle_w'(1);

            // An edge coinciding with the end of a burst opens the next one.
            if (w_done)
                r_pulse_cnt <= r_edge ? LEN_W'(1) : '0;
            else if (r_edge && (r_pulse_cnt != '1))
                r_pulse_cnt <= r_pulse_cnt + LEN_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ir_receiver_sm.sv
`default_nettype none
// ============================================================================
//  Module   : ir_receiver_sm
//  Purpose  : Decodes the car-control IR packet: start burst, car-select
//             burst, then CMD_LEN data bursts (MSB first). Reports the
//             decoded command and car index with a one-cycle valid strobe
//             and flags aborted packets with a one-cycle error strobe.
//  Ports    : clk             in   system clock
//             rst_n           in   asynchronous active-low reset
//             i_ir_in         in   raw modulated IR input (asynchronous)
//             o_command       out  last valid command {right,left,back,fwd}
//             o_car_id        out  car index of the last valid packet
//             o_packet_valid  out  1-cycle strobe: command/car id updated
//             o_pkt_error     out  1-cycle strobe: packet aborted
//  Revision : 1.0 - initial release
// ============================================================================
module ir_receiver_sm
    import ir_receiver_sm_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int CARRIER_HZ   = 36_000,
    parameter int TOL          = 4,
    parameter int EDGE_TIMEOUT = 2 * CLK_FREQ_HZ / CARRIER_HZ,
    parameter int MAX_GAP_CYC  = int'(64'(60) * 64'(CLK_FREQ_HZ) / 64'(CARRIER_HZ))
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_ir_in,
    output logic [CMD_LEN-1:0]  o_command,
    output logic [CAR_ID_W-1:0] o_car_id,
    output logic                o_packet_valid,
    output logic                o_pkt_error
);

    localparam int c_gap_w = $clog2(MAX_GAP_CYC + 1);
    localparam logic [c_gap_w-1:0] c_gap_max = c_gap_w'(MAX_GAP_CYC);

    if (!classes_disjoint(TOL)) begin : g_class_overlap
        $error("ir_receiver_sm: burst class tolerance windows overlap");
    end

    logic                w_burst_done;
    logic [LEN_W-1:0]    w_burst_len;
    logic                w_meter_busy;

    rx_state_t           r_state,       w_state_nxt;
    logic [BIT_IDX_W-1:0] r_bit_idx,    w_bit_idx_nxt;
    logic [CMD_LEN-1:0]  r_shadow,      w_shadow_nxt;
    logic [CMD_LEN-1:0]  w_shadow_ins;
    logic [CMD_LEN-1:0]  r_command,     w_command_nxt;
    logic [CAR_ID_W-1:0] r_car_latch,   w_car_latch_nxt;
    logic [CAR_ID_W-1:0] r_car_id,      w_car_id_nxt;
    logic                r_packet_valid, w_packet_valid_nxt;
    logic                r_pkt_error,   w_pkt_error_nxt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic                w_gap_timeout;

    logic                w_is_start;
    logic                w_is_assert;
    logic                w_is_deassert;
    logic                w_car_hit;
    logic [CAR_ID_W-1:0] w_car_idx;

    ir_receiver_sm_burst_meter #(
        .EDGE_TIMEOUT (EDGE_TIMEOUT)
    ) u_meter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ir_in      (i_ir_in),
        .o_burst_done (w_burst_done),
        .o_burst_len  (w_burst_len),
        .o_busy       (w_meter_busy)
    );

    // Burst classification.
    assign w_is_start    = burst_match(w_burst_len, START_BURST, TOL);
    assign w_is_assert   = burst_match(w_burst_len, ASSERT_BURST, TOL);
    assign w_is_deassert = burst_match(w_burst_len, DEASSERT_BURST, TOL);

    always_comb begin
        w_car_hit = 1'b0;
        w_car_idx = '0;
        for (int i = 0; i < CAR_COUNT; i++) begin
            if (burst_match(w_burst_len, CAR_SELECT_BURST[CAR_ID_W'(i)], TOL)) begin
                w_car_hit = 1'b1;
                w_car_idx = CAR_ID_W'(i);
            end
        end
    end

    // The silence counter is held clear while a burst is being counted, so it
    // measures only the quiet time since the last burst ended.
    assign w_gap_timeout = (r_gap_cnt == c_gap_max) && !w_meter_busy;

    always_comb begin
        w_state_nxt        = r_state;
        w_bit_idx_nxt      = r_bit_idx;
        w_shadow_nxt       = r_shadow;
        w_car_latch_nxt    = r_car_latch;
        w_command_nxt      = r_command;
        w_car_id_nxt       = r_car_id;
        w_packet_valid_nxt = 1'b0;
        w_pkt_error_nxt    = 1'b0;
        w_shadow_ins       = r_shadow;
        w_shadow_ins[r_bit_idx] = w_is_assert;

        // A finished burst takes priority over the gap timeout.
        if (w_burst_done) begin
            case (r_state)
                WAIT_START: begin
                    if (w_is_start)
                        w_state_nxt = WAIT_CAR;
                end
                WAIT_CAR: begin
                    if (w_is_start) begin
                        w_state_nxt = WAIT_CAR;
                    end else if (w_car_hit) begin
                        w_car_latch_nxt = w_car_idx;
                        w_bit_idx_nxt   = BIT_IDX_W'(CMD_LEN - 1);
                        w_shadow_nxt    = '0;
                        w_state_nxt     = WAIT_BITS;
                    end else begin
                        w_pkt_error_nxt = 1'b1;
                        w_state_nxt     = WAIT_START;
                    end
                end
                WAIT_BITS: begin
                    if (w_is_start) begin
                        w_state_nxt = WAIT_CAR;
                    end else if (w_is_assert || w_is_deassert) begin
                        w_shadow_nxt = w_shadow_ins;
                        if (r_bit_idx == '0) begin
                            w_command_nxt      = w_shadow_ins;
                            w_car_id_nxt       = r_car_latch;
                            w_packet_valid_nxt = 1'b1;
                            w_state_nxt        = WAIT_START;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx - BIT_IDX_W'(1);
                        end
                    end else begin
                        w_pkt_error_nxt = 1'b1;
                        w_state_nxt     = WAIT_START;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_START;
                end
            endcase
        end else if (w_gap_timeout && (r_state != WAIT_START)) begin
            w_pkt_error_nxt = 1'b1;
            w_state_nxt     = WAIT_START;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= WAIT_START;
            r_bit_idx      <= '0;
            r_shadow       <= '0;
            r_car_latch    <= '0;
            r_command      <= '0;
            r_car_id       <= '0;
            r_packet_valid <= 1'b0;
            r_pkt_error    <= 1'b0;
            r_gap_cnt      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_bit_idx      <= w_bit_idx_nxt;
            r_shadow       <= w_shadow_nxt;
            r_car_latch    <= w_car_latch_nxt;
            r_command      <= w_command_nxt;
            r_car_id       <= w_car_id_nxt;
            r_packet_valid <= w_packet_valid_nxt;
            r_pkt_error    <= w_pkt_error_nxt;
            if (w_meter_busy)
                r_gap_cnt <= '0;
            else if (r_gap_cnt != c_gap_max)
                r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
        end
    end

    assign o_command      = r_command;
    assign o_car_id       = r_car_id;
    assign o_packet_valid = r_packet_valid;
    assign o_pkt_error    = r_pkt_error;

endmodule
`default_nettype wire

// File: tb/tb_ir_receiver_sm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_receiver_sm
//  Purpose  : Self-checking bench for ir_receiver_sm. A scaled clock/carrier
//             ratio (6 clocks per carrier period) keeps packets short.
//             Decoded packets are checked against a queue of expected
//             {command, car id} pairs pushed when each packet is sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ir_receiver_sm;
    import ir_receiver_sm_pkg::*;

    localparam int c_clk_hz     = 600_000;
    localparam int c_car_hz     = 100_000;
    localparam int c_tol        = 4;
    localparam int c_half       = (c_clk_hz / c_car_hz) / 2;   // 3 clocks
    localparam int c_edge_to    = 2 * c_clk_hz / c_car_hz;     // 12 clocks
    localparam int c_max_gap    = 60 * c_clk_hz / c_car_hz;    // 360 clocks
    localparam int c_gap_pulses = 25;
    localparam int c_nvec       = 9;

    typedef struct packed {
        logic [CMD_LEN-1:0]  cmd;
        logic [CAR_ID_W-1:0] id;
    } exp_t;

    typedef struct packed {
        int                  s;      // start burst length
        int                  c;      // car-select burst length
        int                  b0;     // data bursts in send order (MSB first)
        int                  b1;
        int                  b2;
        int                  b3;
        bit                  v;      // packet expected to decode
        logic [CMD_LEN-1:0]  cmd;
        logic [CAR_ID_W-1:0] id;
        int                  err;    // expected error strobes
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                r_ir_in;
    logic [CMD_LEN-1:0]  w_command;
    logic [CAR_ID_W-1:0] w_car_id;
    logic                w_packet_valid;
    logic                w_pkt_error;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs [c_nvec];

    int n_checks     = 0;
    int n_pass       = 0;
    int n_valid      = 0;
    int n_err        = 0;
    int cyc          = 0;
    int last_err_cyc = -1;

    logic [CMD_LEN-1:0]  last_cmd;
    logic [CAR_ID_W-1:0] last_id;

    ir_receiver_sm #(
        .CLK_FREQ_HZ (c_clk_hz),
        .CARRIER_HZ  (c_car_hz),
        .TOL         (c_tol)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ir_in        (r_ir_in),
        .o_command      (w_command),
        .o_car_id       (w_car_id),
        .o_packet_valid (w_packet_valid),
        .o_pkt_error    (w_pkt_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi)
            n_pass++;
        else
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    endtask

    // Output monitor: strobes sampled on the falling edge.
    always begin
        @(negedge clk);
        if (w_packet_valid) begin
            n_valid++;
            check("valid_was_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("valid_command", int'(w_command), int'(mon_e.cmd));
                check("valid_car_id", int'(w_car_id), int'(mon_e.id));
            end
        end
        if (w_pkt_error) begin
            n_err++;
            last_err_cyc = cyc;
        end
    end

    task automatic burst(input int n);
        for (int k = 0; k < n; k++) begin
            r_ir_in = 1'b1;
            repeat (c_half) @(negedge clk);
            r_ir_in = 1'b0;
            repeat (c_half) @(negedge clk);
        end
    endtask

    task automatic gap(input int pulses);
        repeat (pulses * 2 * c_half) @(negedge clk);
    endtask

    task automatic send_packet(input int s, input int c, input int b0,
                               input int b1, input int b2, input int b3);
        burst(s);  gap(c_gap_pulses);
        burst(c);  gap(c_gap_pulses);
        burst(b0); gap(c_gap_pulses);
        burst(b1); gap(c_gap_pulses);
        burst(b2); gap(c_gap_pulses);
        burst(b3); gap(c_gap_pulses);
    endtask

    task automatic expect_packet(input logic [CMD_LEN-1:0] cmd, input logic [CAR_ID_W-1:0] id);
        exp_t e;
        e.cmd = cmd;
        e.id  = id;
        exp_q.push_back(e);
    endtask

    initial begin
        int e0;
        int v0;
        int t0;

        // Car bursts: 0->72, 1->97, 2->122, 3->147. Data: 1->47, 0->22.
        vecs[0] = '{191,  97, 22, 47, 22, 47, 1'b1, 4'b0101, 2'd1, 0};
        vecs[1] = '{187, 122, 47, 47, 22, 22, 1'b1, 4'b1100, 2'd2, 0};
        vecs[2] = '{195, 151, 18, 26, 51, 43, 1'b1, 4'b0011, 2'd3, 0};
        vecs[3] = '{191,  68, 47, 47, 47, 47, 1'b1, 4'b1111, 2'd0, 0};
        vecs[4] = '{191,  97, 22, 47, 35, 47, 1'b0, 4'b0000, 2'd0, 1};
        vecs[5] = '{186,  97, 22, 47, 22, 47, 1'b0, 4'b0000, 2'd0, 0};
        vecs[6] = '{196,  97, 22, 47, 22, 47, 1'b0, 4'b0000, 2'd0, 0};
        vecs[7] = '{191,  85, 47, 47, 47, 47, 1'b0, 4'b0000, 2'd0, 1};
        vecs[8] = '{191,  72, 52, 47, 47, 47, 1'b0, 4'b0000, 2'd0, 1};

        // Reset state
        rst_n    = 1'b0;
        r_ir_in  = 1'b0;
        last_cmd = '0;
        last_id  = '0;
        repeat (3) @(negedge clk);
        check("reset_command", int'(w_command), 0);
        check("reset_car_id", int'(w_car_id), 0);
        check("reset_valid", int'(w_packet_valid), 0);
        check("reset_error", int'(w_pkt_error), 0);
        rst_n = 1'b1;

        // Idle after reset: no strobes
        e0 = n_err;
        v0 = n_valid;
        repeat (1000) @(negedge clk);
        check("idle_strobes", (n_err - e0) + (n_valid - v0), 0);

        // Table-driven packets
        for (int i = 0; i < c_nvec; i++) begin
            e0 = n_err;
            v0 = n_valid;
            if (vecs[i].v)
                expect_packet(vecs[i].cmd, vecs[i].id);
            send_packet(vecs[i].s, vecs[i].c, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            check($sformatf("v%0d_errors", i), n_err - e0, vecs[i].err);
            check($sformatf("v%0d_valids", i), n_valid - v0, int'(vecs[i].v));
            check($sformatf("v%0d_pending", i), exp_q.size(), 0);
            exp_q.delete();
            if (vecs[i].v) begin
                last_cmd = vecs[i].cmd;
                last_id  = vecs[i].id;
            end
            check($sformatf("v%0d_command_hold", i), int'(w_command), int'(last_cmd));
            check($sformatf("v%0d_car_id_hold", i), int'(w_car_id), int'(last_id));
        end

        // Gap timeout after the car-select burst
        e0 = n_err;
        burst(191); gap(c_gap_pulses);
        burst(97);
        t0 = cyc;
        repeat (2 * c_max_gap) @(negedge clk);
        check("timeout_errors", n_err - e0, 1);
        check_range("timeout_latency", last_err_cyc - t0, c_max_gap, c_max_gap + c_edge_to + 16);
        check("timeout_command_hold", int'(w_command), int'(last_cmd));
        e0 = n_err;
        v0 = n_valid;
        expect_packet(4'b1010, 2'd2);
        send_packet(191, 122, 47, 22, 47, 22);
        check("after_timeout_errors", n_err - e0, 0);
        check("after_timeout_valids", n_valid - v0, 1);
        check("after_timeout_command", int'(w_command), 32'hA);
        exp_q.delete();
        last_cmd = 4'b1010;
        last_id  = 2'd2;

        // Resync: new start burst after two data bits
        e0 = n_err;
        v0 = n_valid;
        burst(191); gap(c_gap_pulses);
        burst(97);  gap(c_gap_pulses);
        burst(47);  gap(c_gap_pulses);
        burst(22);  gap(c_gap_pulses);
        expect_packet(4'b0011, 2'd3);
        send_packet(191, 147, 22, 22, 47, 47);
        check("resync_errors", n_err - e0, 0);
        check("resync_valids", n_valid - v0, 1);
        check("resync_command", int'(w_command), 3);
        check("resync_car_id", int'(w_car_id), 3);
        exp_q.delete();

        // Reset in the middle of the second data bit
        e0 = n_err;
        v0 = n_valid;
        burst(191); gap(c_gap_pulses);
        burst(72);  gap(c_gap_pulses);
        burst(47);  gap(c_gap_pulses);
        burst(10);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_command", int'(w_command), 0);
        check("midreset_car_id", int'(w_car_id), 0);
        rst_n = 1'b1;
        gap(c_gap_pulses);
        check("midreset_strobes", (n_err - e0) + (n_valid - v0), 0);
        check("midreset_command_held", int'(w_command), 0);
        e0 = n_err;
        v0 = n_valid;
        expect_packet(4'b1001, 2'd0);
        send_packet(191, 72, 47, 22, 22, 47);
        check("post_reset_errors", n_err - e0, 0);
        check("post_reset_valids", n_valid - v0, 1);
        check("post_reset_command", int'(w_command), 9);
        check("post_reset_car_id", int'(w_car_id), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
